io_seg7_ctrl: RTL and testbench
===============================

Name: io_seg7_ctrl

Overview:
- Memory-mapped 8-digit seven-segment display controller on the CPU data bus, downstream of the core.
- Bus inputs connect alongside DRAM: address = ALU result, write data = rD2, write enable = dram_we.
- The SoC read mux selects this block's read data when it asserts io_hit.
- A free-running scan counter time-multiplexes the digits onto the board's shared segment lines.

Parameters:
- BASE_ADDR, 32'hFFFF_F000, byte address of the DATA register; CTRL is at BASE_ADDR+4.
- SCAN_DIV, 50000, cpu_clk cycles each digit is lit. Must be ≥1; simulation uses 4.

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge.
- cpu_rst_n  in  1  asynchronous reset, active-low.
- addr  in  32  bus byte address (ALU result).
- we  in  1  bus write enable (dram_we).
- wdata  in  32  bus write data (rD2).
- rdata  out  32  combinational read data; 0 when not hit.
- io_hit  out  1  combinational; 1 when addr[31:3] == BASE_ADDR[31:3].
- dig_en  out  8  digit enables, active-low, registered; bit i = digit i (digit 0 rightmost).
- seg  out  8  segment lines, active-low, registered; order {DP,G,F,E,D,C,B,A}.

Behaviour:
- Registers:
  - DATA: offset 0 (addr[2]=0). 32 bits; nibble i is shown on digit i.
  - CTRL: offset 4 (addr[2]=1). [7:0] digit enable mask (1=shown); [15:8] decimal-point mask (1=DP lit); [31:16] read as 0, writes ignored.
- Write: on a cpu_clk rising edge with we=1 and io_hit=1, write wdata into the register selected by addr[2]. addr[1:0] is ignored. Full-word writes only.
- Read: combinational, zero latency, to suit the single-cycle core.
  - rdata = DATA or {16'h0, CTRL[15:0]} when io_hit=1; otherwise 0.
  - A read in the same cycle as a write returns the old value.
- Reset (async assert on cpu_rst_n=0; async assert, sync-released by the SoC):
  - DATA=0, CTRL=32'h0000_00FF, scan counter=0, digit index=0.
  - dig_en=8'hFF, seg=8'hFF (all dark).
  - Reset mid-scan blanks the display immediately.
- Scan counter:
  - Width $clog2(SCAN_DIV), minimum 1.
  - Increments every cycle; at SCAN_DIV-1 it wraps to 0 and the digit index advances (7 wraps to 0).
  - SCAN_DIV=1: the index advances every cycle.
- Output stage, registered, one cycle latency from index or register state:
  - dig_en: all ones except bit idx cleared, when CTRL[idx]=1. If CTRL[idx]=0, dig_en=8'hFF for that slot; the slot is not skipped, so timing stays uniform.
  - seg[6:0] = hex decode of DATA[4*idx+3 -: 4], active-low. Codes with DP off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - seg[7] = ~CTRL[8+idx].
- Write during a digit's slot: new glyph appears on the output the cycle after the write edge. No glitch or extra blank cycle.
- Addresses outside the 8-byte window are ignored, even with we=1.

Test Plan (SCAN_DIV=4):
- Reset: hold cpu_rst_n=0 -> dig_en=8'hFF, seg=8'hFF, rdata@BASE=0, rdata@BASE+4=32'h00FF. Then release -> first cycle after release gives dig_en=8'hFE, seg=8'hC0.
- Write: we=1, addr=BASE, wdata=32'h8765_4321 -> DATA reads 32'h8765_4321. Across 32 cycles dig_en steps FE,FD,FB,…,7F, 4 cycles each; seg steps F9,A4,B0,99,92,82,F8,80; pattern then wraps.
- Masks: write CTRL=32'hFFFF_0F05 -> CTRL reads 32'h0000_0F05. Digits 1 and 3–7 dark (dig_en=FF in those slots); digits 0 and 2 have DP lit (seg[7]=0).
- Mid-slot update: write DATA=32'h0000_000F while idx=0 -> seg=8'h8E one cycle after the write edge; dig_en unchanged.
- Address decode: we=1, addr=BASE+8, wdata=32'hFFFF_FFFF -> io_hit=0, rdata=0, DATA and CTRL unchanged.
- Async reset mid-scan: pull cpu_rst_n low between clock edges at idx=5 -> outputs go FF/FF with no clock edge; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/io_seg7_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: DATA/CTRL registers on the CPU bus,
// plus a free-running scan that time-multiplexes one digit at a time onto shared segment lines.
module io_seg7_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
    parameter int          SCAN_DIV  = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        io_hit,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q, data_d;
    logic [15:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       dig_en_q, dig_en_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nibble;

    // Active-low glyphs for hex digits, bit order {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign io_hit = (addr[31:3] == BASE_ADDR[31:3]);

    always_comb begin
        rdata = 32'h0;
        if (io_hit) begin
            rdata = addr[2] ? {16'h0, ctrl_q} : data_q;
        end
    end

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (we && io_hit) begin
            if (addr[2]) begin
                ctrl_d = wdata[15:0];
            end else begin
                data_d = wdata;
            end
        end
    end

    // Slots are never skipped for masked digits, so every digit gets equal on-time.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
        nibble   = data_q[{idx_q, 2'b00} +: 4];
        dig_en_d = ctrl_q[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d    = {~ctrl_q[{1'b1, idx_q}], hex7(nibble)};
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            data_q   <= 32'h0;
            ctrl_q   <= 16'h00FF;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            dig_en_q <= 8'hFF;
            seg_q    <= 8'hFF;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
        end
    end

    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_io_seg7_ctrl.sv
// Directed self-checking bench for io_seg7_ctrl with SCAN_DIV=4; inputs change and outputs
// are sampled on the falling clock edge, so "edge k" below means the k-th rising edge after reset release.
module tb_io_seg7_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_F000;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        io_hit;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    io_seg7_ctrl #(.BASE_ADDR(BASE), .SCAN_DIV(4)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .io_hit   (io_hit),
        .dig_en   (dig_en),
        .seg      (seg)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr  = a;
        we    = w;
        wdata = d;
    endtask

    // Digit enables and glyphs for DATA=32'h8765_4321, CTRL=8'hFF (DP off)
    logic [7:0] expDig [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] expSeg [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    // Same DATA with CTRL=16'h0F05: digits 0,2 shown; DP lit on digits 0..3
    logic [7:0] mskDig [8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] mskSeg [8] = '{8'h79, 8'h24, 8'h30, 8'h19, 8'h92, 8'h82, 8'hF8, 8'h80};

    initial begin
        int d;
        cpu_rst_n = 1'b0;
        applyStimulus(BASE, 1'b0, 32'h0);

        // Held in reset across several clock edges
        repeat (3) @(negedge cpu_clk);
        #1;
        checkOutput("rst_dig_en", {24'h0, dig_en}, 32'h0000_00FF);
        checkOutput("rst_seg", {24'h0, seg}, 32'h0000_00FF);
        checkOutput("rst_data", rdata, 32'h0);
        addr = BASE + 32'd4;
        #1;
        checkOutput("rst_ctrl", rdata, 32'h0000_00FF);
        checkOutput("rst_hit", {31'h0, io_hit}, 32'h1);

        // Release and write DATA on edge 1
        cpu_rst_n = 1'b1;
        applyStimulus(BASE, 1'b1, 32'h8765_4321);
        @(negedge cpu_clk);
        we = 1'b0;
        #1;
        checkOutput("first_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        checkOutput("first_seg", {24'h0, seg}, 32'h0000_00C0);
        checkOutput("data_rd", rdata, 32'h8765_4321);

        // Edges 2..33: full scan round plus the wrap back to digit 0
        for (int k = 2; k <= 33; k++) begin
            @(negedge cpu_clk);
            d = ((k - 1) / 4) % 8;
            checkOutput($sformatf("scan_dig_en_e%0d", k), {24'h0, dig_en}, {24'h0, expDig[d]});
            checkOutput($sformatf("scan_seg_e%0d", k), {24'h0, seg}, {24'h0, expSeg[d]});
        end

        // Write CTRL on edge 34; upper half must read back as zero
        applyStimulus(BASE + 32'd4, 1'b1, 32'hFFFF_0F05);
        @(negedge cpu_clk);
        we = 1'b0;
        #1;
        checkOutput("ctrl_rd", rdata, 32'h0000_0F05);

        for (int k = 35; k <= 66; k++) begin
            @(negedge cpu_clk);
            d = ((k - 1) / 4) % 8;
            checkOutput($sformatf("mask_dig_en_e%0d", k), {24'h0, dig_en}, {24'h0, mskDig[d]});
            checkOutput($sformatf("mask_seg_e%0d", k), {24'h0, seg}, {24'h0, mskSeg[d]});
        end

        // Restore CTRL on edge 67, then run to edge 97 (digit 0 slot spans edges 97..100)
        applyStimulus(BASE + 32'd4, 1'b1, 32'h0000_00FF);
        @(negedge cpu_clk);
        we = 1'b0;
        repeat (30) @(negedge cpu_clk);

        // Mid-slot DATA write on edge 98; the read in the write cycle sees the old value
        applyStimulus(BASE, 1'b1, 32'h0000_000F);
        #1;
        checkOutput("rd_during_wr", rdata, 32'h8765_4321);
        @(negedge cpu_clk);
        we = 1'b0;
        @(negedge cpu_clk);
        checkOutput("midslot_seg", {24'h0, seg}, 32'h0000_008E);
        checkOutput("midslot_dig_en", {24'h0, dig_en}, 32'h0000_00FE);

        // Write just outside the window on edge 100 must be ignored
        applyStimulus(BASE + 32'd8, 1'b1, 32'hFFFF_FFFF);
        #1;
        checkOutput("oob_hit", {31'h0, io_hit}, 32'h0);
        checkOutput("oob_rdata", rdata, 32'h0);
        @(negedge cpu_clk);
        applyStimulus(BASE, 1'b0, 32'h0);
        #1;
        checkOutput("oob_data_kept", rdata, 32'h0000_000F);
        addr = BASE + 32'd7;
        #1;
        checkOutput("top_byte_hit", {31'h0, io_hit}, 32'h1);
        checkOutput("oob_ctrl_kept", rdata, 32'h0000_00FF);
        addr = BASE - 32'd4;
        #1;
        checkOutput("below_hit", {31'h0, io_hit}, 32'h0);
        checkOutput("below_rdata", rdata, 32'h0);

        // Run to edge 118 (digit 5 slot), then reset between clock edges
        repeat (18) @(negedge cpu_clk);
        #1;
        checkOutput("pre_rst_dig_en", {24'h0, dig_en}, 32'h0000_00DF);
        checkOutput("pre_rst_seg", {24'h0, seg}, 32'h0000_00C0);
        #1;
        cpu_rst_n = 1'b0;
        #1;
        checkOutput("async_dig_en", {24'h0, dig_en}, 32'h0000_00FF);
        checkOutput("async_seg", {24'h0, seg}, 32'h0000_00FF);
        addr = BASE;
        #1;
        checkOutput("async_data", rdata, 32'h0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        checkOutput("restart_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        checkOutput("restart_seg", {24'h0, seg}, 32'h0000_00C0);
        repeat (3) @(negedge cpu_clk);
        checkOutput("restart_e4_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
        @(negedge cpu_clk);
        checkOutput("restart_e5_dig_en", {24'h0, dig_en}, 32'h0000_00FD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
